// File: rtl/mips_mdu_if.sv
// Handshake and result bundle between the EX-stage controller and the multiply/divide unit.
interface mips_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cancel;
    logic             busy;
    logic             stall_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B, cancel,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, op, A, B, cancel,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/mips_mdu.sv
// Multi-cycle MIPS multiply/divide unit: the result is computed at launch, held pending,
// and committed to HI/LO when the busy countdown expires unless cancelled first.
module mips_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    mips_mdu_if.slave bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt_p1;
    logic [WIDTH-1:0]     pend_hi_p1, pend_lo_p1;
    logic                 pend_wr_p1;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic [2*WIDTH-1:0]   res_p0;
    logic                 res_wr_p0;
    logic                 is_md;
    logic                 busy;

    function automatic logic [2*WIDTH-1:0] mul_s(input logic signed [WIDTH-1:0] a,
                                                 input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] ax, bx, p;
        ax = a;
        bx = b;
        p  = ax * bx;
        return p;
    endfunction

    function automatic logic [2*WIDTH-1:0] mul_u(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] ax, bx;
        ax = {{WIDTH{1'b0}}, a};
        bx = {{WIDTH{1'b0}}, b};
        return ax * bx;
    endfunction

    // Returns {remainder, quotient}; the divisor is non-zero at every call site.
    function automatic logic [2*WIDTH-1:0] div_s(input logic signed [WIDTH-1:0] a,
                                                 input logic signed [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] q, r;
        if (a == $signed(MOST_NEG) && b == -1) begin
            return {{WIDTH{1'b0}}, MOST_NEG};
        end
        q = a / b;
        r = a % b;
        return {r, q};
    endfunction

    function automatic logic [2*WIDTH-1:0] div_u(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        return {a % b, a / b};
    endfunction

    assign is_md = ~bus.op[2];

    // Stage 0: combinational result of the operation offered at launch
    always_comb begin
        res_p0    = '0;
        res_wr_p0 = 1'b0;
        case (bus.op)
            OP_MULT:  begin res_p0 = mul_s(bus.A, bus.B); res_wr_p0 = 1'b1; end
            OP_MULTU: begin res_p0 = mul_u(bus.A, bus.B); res_wr_p0 = 1'b1; end
            OP_DIV:   if (bus.B != '0) begin res_p0 = div_s(bus.A, bus.B); res_wr_p0 = 1'b1; end
            OP_DIVU:  if (bus.B != '0) begin res_p0 = div_u(bus.A, bus.B); res_wr_p0 = 1'b1; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start && is_md) state_nxt = S_BUSY;
            S_BUSY: if (bus.cancel || cnt_p1 == CNT_W'(1)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state == S_BUSY);
        bus.busy      = busy;
        bus.stall_req = busy | (bus.start & is_md);
    end

    // Stage 1: pending result and countdown; commit to HI/LO when the count expires
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_p1     <= '0;
            pend_hi_p1 <= '0;
            pend_lo_p1 <= '0;
            pend_wr_p1 <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else if (state == S_IDLE) begin
            if (bus.start) begin
                if (is_md) begin
                    pend_hi_p1 <= res_p0[2*WIDTH-1:WIDTH];
                    pend_lo_p1 <= res_p0[WIDTH-1:0];
                    pend_wr_p1 <= res_wr_p0;
                    cnt_p1     <= bus.op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end else if (bus.op == OP_MTHI) begin
                    hi_q <= bus.A;
                end else if (bus.op == OP_MTLO) begin
                    lo_q <= bus.A;
                end
            end
        end else begin
            if (bus.cancel) begin
                cnt_p1     <= '0;
                pend_wr_p1 <= 1'b0;
            end else begin
                cnt_p1 <= cnt_p1 - CNT_W'(1);
                if (cnt_p1 == CNT_W'(1)) begin
                    pend_wr_p1 <= 1'b0;
                    if (pend_wr_p1) begin
                        hi_q <= pend_hi_p1;
                        lo_q <= pend_lo_p1;
                    end
                end
            end
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
endmodule

// File: tb/tb_mips_mdu.sv
// Directed bench for mips_mdu: expected HI/LO are queued at issue and checked when busy falls.
module tb_mips_mdu;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mips_mdu_if #(.WIDTH(W)) bus ();

    mips_mdu #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic mon_prev = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every falling edge of busy retires one scoreboard entry
    initial begin
        forever begin
            @(negedge clk);
            if (mon_prev && !bus.busy) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_busy_drop: got hi=%h lo=%h, expected no completion", bus.hi, bus.lo);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_hi"}, 64'(bus.hi), 64'(mon_e.hi));
                    check({mon_e.name, "_lo"}, 64'(bus.lo), 64'(mon_e.lo));
                end
            end
            mon_prev = bus.busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.start  = 1'b0;
        bus.op     = 3'b110;
        bus.A      = '0;
        bus.B      = '0;
        bus.cancel = 1'b0;
    endtask

    task automatic launch(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
        @(negedge clk);
        check("stall_req_at_launch", 64'(bus.stall_req), 64'(1));
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 3'b110;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_md(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input int cyc);
        int n;
        sb.push_back('{ehi, elo, name});
        launch(op, a, b);
        count_busy(n);
        check({name, "_busy_cycles"}, 64'(n), 64'(cyc));
    endtask

    task automatic mt(input string name, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] ehi, input logic [W-1:0] elo);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.A = a;
        @(negedge clk);
        check({name, "_stall_req"}, 64'(bus.stall_req), 64'(0));
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 3'b110;
        @(negedge clk);
        check({name, "_hi"}, 64'(bus.hi), 64'(ehi));
        check({name, "_lo"}, 64'(bus.lo), 64'(elo));
        check({name, "_busy"}, 64'(bus.busy), 64'(0));
    endtask

    initial begin
        int n;
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus.busy), 64'(0));
        check("reset_stall_req", 64'(bus.stall_req), 64'(0));
        check("reset_hi", 64'(bus.hi), 64'(0));
        check("reset_lo", 64'(bus.lo), 64'(0));
        reset = 1'b1;

        run_md("mult_neg3x5",     3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
        run_md("multu_max_x2",    3'b001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5);
        run_md("multu_max_sq",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
        run_md("mult_min_sq",     3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5);
        run_md("div_neg7_by2",    3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        run_md("div_7_by_neg2",   3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10);
        run_md("div_min_by_neg1", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);

        // DIVU 7/2 launched with cancel asserted in the same cycle: start wins
        sb.push_back('{32'h1, 32'h3, "divu_start_cancel"});
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'b011; bus.A = 32'd7; bus.B = 32'd2; bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 3'b110; bus.cancel = 1'b0;
        count_busy(n);
        check("divu_start_cancel_busy_cycles", 64'(n), 64'(10));

        // Reserved ops do nothing
        for (int k = 6; k <= 7; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b1; bus.op = 3'(k); bus.A = 32'hDEAD; bus.B = 32'h1;
            @(negedge clk);
            check("reserved_stall_req", 64'(bus.stall_req), 64'(0));
            @(posedge clk); #1;
            bus.start = 1'b0; bus.op = 3'b110;
            @(negedge clk);
            check("reserved_busy", 64'(bus.busy), 64'(0));
            check("reserved_hilo", {bus.hi, bus.lo}, {32'h1, 32'h3});
        end

        mt("mthi", 3'b100, 32'h00001234, 32'h00001234, 32'h00000003);
        mt("mtlo", 3'b101, 32'h00005678, 32'h00001234, 32'h00005678);
        run_md("div_by_zero", 3'b010, 32'h00000005, 32'h00000000, 32'h00001234, 32'h00005678, 10);

        // start (MTLO) while busy is ignored
        sb.push_back('{32'hFFFFFFFF, 32'hFFFFFFF2, "mult_ignore_start"});
        launch(3'b000, 32'h00000007, 32'hFFFFFFFE);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'b101; bus.A = 32'h0000AAAA;
        @(negedge clk);
        check("busy_stall_req", 64'(bus.stall_req), 64'(1));
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 3'b110;
        @(negedge clk);
        check("lo_during_busy", 64'(bus.lo), 64'(32'h00005678));
        count_busy(n);
        check("mult_ignore_start_rest_cycles", 64'(n), 64'(3));

        // Reset mid-divide: immediate clear and no later commit
        sb.push_back('{32'h0, 32'h0, "reset_abort"});
        launch(3'b010, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset_async_busy", 64'(bus.busy), 64'(0));
        check("reset_async_hilo", {bus.hi, bus.lo}, 64'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("no_late_commit_hilo", {bus.hi, bus.lo}, 64'(0));
        check("no_late_commit_busy", 64'(bus.busy), 64'(0));

        mt("mthi2", 3'b100, 32'h11112222, 32'h11112222, 32'h00000000);
        mt("mtlo2", 3'b101, 32'h33334444, 32'h11112222, 32'h33334444);

        // Cancel mid-divide keeps prior HI/LO
        sb.push_back('{32'h11112222, 32'h33334444, "cancel_div"});
        launch(3'b010, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        check("cancel_div_busy", 64'(bus.busy), 64'(0));

        // Cancel in the final busy cycle beats the commit
        sb.push_back('{32'h11112222, 32'h33334444, "cancel_last"});
        launch(3'b000, 32'd3, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        check("cancel_last_still_busy", 64'(bus.busy), 64'(1));
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        check("cancel_last_busy", 64'(bus.busy), 64'(0));

        run_md("mult_after_cancel", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5);

        // Cancel while idle has no effect
        @(posedge clk); #1;
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        check("idle_cancel_hilo", {bus.hi, bus.lo}, {32'h0, 32'h1});
        check("idle_cancel_busy", 64'(bus.busy), 64'(0));

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
